// File: rtl/elev_pkg.sv
// Shared elevator constants: change_floor direction encodings, default floor
// limits and the building's stop floors.
package elev_pkg;

  typedef enum logic [1:0] {
    DIR_HOLD = 2'b00,
    DIR_DN   = 2'b01,
    DIR_UP   = 2'b10,
    DIR_ILL  = 2'b11
  } dir_e;

  localparam int FLOOR_MIN_DEF = 1;
  localparam int FLOOR_MAX_DEF = 8;

  localparam logic [3:0] STOP_FLOOR_0 = 4'd1;
  localparam logic [3:0] STOP_FLOOR_1 = 4'd3;
  localparam logic [3:0] STOP_FLOOR_2 = 4'd6;
  localparam logic [3:0] STOP_FLOOR_3 = 4'd8;

endpackage

// File: rtl/seg7_decode.sv
// Hex digit to active-low seven-segment pattern, bit order {dp,g,f,e,d,c,b,a}.
module seg7_decode (
  input  logic [3:0] hex_i,
  output logic [7:0] seg_o
);

  always_comb begin
    seg_o = 8'hFF;
    case (hex_i)
      4'h0: seg_o = 8'hC0;
      4'h1: seg_o = 8'hF9;
      4'h2: seg_o = 8'hA4;
      4'h3: seg_o = 8'hB0;
      4'h4: seg_o = 8'h99;
      4'h5: seg_o = 8'h92;
      4'h6: seg_o = 8'h82;
      4'h7: seg_o = 8'hF8;
      4'h8: seg_o = 8'h80;
      4'h9: seg_o = 8'h90;
      4'hA: seg_o = 8'h88;
      4'hB: seg_o = 8'h83;
      4'hC: seg_o = 8'hC6;
      4'hD: seg_o = 8'hA1;
      4'hE: seg_o = 8'h86;
      4'hF: seg_o = 8'h8E;
      default: seg_o = 8'hFF;
    endcase
  end

endmodule

// File: rtl/floor_timer.sv
// Elevator floor tracker with a one-second door countdown.
// Optional seven-segment scan outputs are built when FLOOR_TIMER_SEG_EN is defined.
module floor_timer
  import elev_pkg::*;
#(
  parameter int TICK_DIV  = 50_000_000,
  parameter int FLOOR_MIN = FLOOR_MIN_DEF,
  parameter int FLOOR_MAX = FLOOR_MAX_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] change_floor,
  input  logic       start_cd,
  input  logic [3:0] seconds,
  output logic [3:0] floor,
  output logic [3:0] left,
  output logic       tick,
`ifdef FLOOR_TIMER_SEG_EN
  output logic [3:0] seg_an,
  output logic [7:0] seg_cat,
`endif
  output logic       range_err
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  dir_e          prevDir_q, prevDir_d;
  logic [3:0]    floor_q, floor_d;
  logic [3:0]    left_q, left_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          tick_q, tick_d;
  logic          rangeErr_q, rangeErr_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      prevDir_q  <= DIR_HOLD;
      floor_q    <= 4'(FLOOR_MIN);
      left_q     <= 4'd0;
      presc_q    <= '0;
      tick_q     <= 1'b0;
      rangeErr_q <= 1'b0;
    end else begin
      prevDir_q  <= prevDir_d;
      floor_q    <= floor_d;
      left_q     <= left_d;
      presc_q    <= presc_d;
      tick_q     <= tick_d;
      rangeErr_q <= rangeErr_d;
    end
  end

  // Moves act only on the first cycle after a hold, so a held level moves once.
  always_comb begin
    prevDir_d  = dir_e'(change_floor);
    floor_d    = floor_q;
    rangeErr_d = rangeErr_q;
    if (prevDir_q == DIR_HOLD) begin
      case (dir_e'(change_floor))
        DIR_UP:  if (floor_q < 4'(FLOOR_MAX)) floor_d = floor_q + 4'd1;
                 else rangeErr_d = 1'b1;
        DIR_DN:  if (floor_q > 4'(FLOOR_MIN)) floor_d = floor_q - 4'd1;
                 else rangeErr_d = 1'b1;
        DIR_ILL: rangeErr_d = 1'b1;
        default: ;
      endcase
    end
  end

  // A load always beats a decrement landing in the same cycle.
  always_comb begin
    left_d  = left_q;
    presc_d = presc_q;
    tick_d  = 1'b0;
    if (start_cd) begin
      left_d  = seconds;
      presc_d = '0;
    end else if (left_q != 4'd0) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        left_d  = left_q - 4'd1;
        tick_d  = 1'b1;
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end else begin
      presc_d = '0;
    end
  end

  assign floor     = floor_q;
  assign left      = left_q;
  assign tick      = tick_q;
  assign range_err = rangeErr_q;

`ifdef FLOOR_TIMER_SEG_EN
  // Each of the four digits is lit for 2^16 clocks in turn.
  logic [17:0] scanCnt_q, scanCnt_d;
  logic [1:0]  digit;
  logic [3:0]  hexVal;
  logic [7:0]  segPat;

  always_ff @(posedge clk) begin
    if (!rst) scanCnt_q <= '0;
    else      scanCnt_q <= scanCnt_d;
  end

  always_comb begin
    scanCnt_d = scanCnt_q + 18'd1;
  end

  assign digit  = scanCnt_q[17:16];
  assign hexVal = (digit == 2'd0) ? floor_q : left_q;

  seg7_decode uDecode (
    .hex_i (hexVal),
    .seg_o (segPat)
  );

  assign seg_an  = ~(4'b0001 << digit);
  assign seg_cat = digit[1] ? 8'hFF : segPat;
`endif

endmodule

// File: tb/tb_floor_timer.sv
// Directed self-checking bench for floor_timer with TICK_DIV=4.
module tb_floor_timer;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] change_floor;
  logic       start_cd;
  logic [3:0] seconds;
  logic [3:0] floor;
  logic [3:0] left;
  logic       tick;
  logic       range_err;
`ifdef FLOOR_TIMER_SEG_EN
  logic [3:0] seg_an;
  logic [7:0] seg_cat;
`endif

  int testsRun    = 0;
  int testsFailed = 0;

  floor_timer #(.TICK_DIV(4), .FLOOR_MIN(1), .FLOOR_MAX(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .change_floor (change_floor),
    .start_cd     (start_cd),
    .seconds      (seconds),
    .floor        (floor),
    .left         (left),
    .tick         (tick),
`ifdef FLOOR_TIMER_SEG_EN
    .seg_an       (seg_an),
    .seg_cat      (seg_cat),
`endif
    .range_err    (range_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] cf, input logic sc, input logic [3:0] secs);
    change_floor = cf;
    start_cd     = sc;
    seconds      = secs;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b0;
    applyStimulus(2'b00, 1'b0, 4'd0);
    step(2);
    rst = 1'b1;
  endtask

  // One clean edge of the given direction followed by a return to hold.
  task automatic pulseDir(input logic [1:0] cf);
    applyStimulus(cf, 1'b0, 4'd0);
    step(1);
    applyStimulus(2'b00, 1'b0, 4'd0);
    step(1);
  endtask

  initial begin
    rst = 1'b0;
    applyStimulus(2'b00, 1'b0, 4'd0);
    step(2);
    checkOutput("rst_floor", 32'(floor), 32'd1);
    checkOutput("rst_left", 32'(left), 32'd0);
    checkOutput("rst_tick", 32'(tick), 32'd0);
    checkOutput("rst_err", 32'(range_err), 32'd0);
    rst = 1'b1;

    // Countdown from 3: ticks 4, 8 and 12 cycles after the load edge.
    applyStimulus(2'b00, 1'b1, 4'd3);
    step(1);
    checkOutput("cd_load", 32'(left), 32'd3);
    checkOutput("cd_load_tick", 32'(tick), 32'd0);
    applyStimulus(2'b00, 1'b0, 4'd0);
    for (int k = 1; k <= 16; k++) begin
      step(1);
      checkOutput($sformatf("cd_tick_%0d", k), 32'(tick), (k % 4 == 0 && k <= 12) ? 32'd1 : 32'd0);
      checkOutput($sformatf("cd_left_%0d", k), 32'(left), (k >= 12) ? 32'd0 : 32'(3 - k / 4));
    end

    // Held up level moves once; a second edge moves again.
    applyStimulus(2'b10, 1'b0, 4'd0);
    step(1);
    checkOutput("hold_up_1", 32'(floor), 32'd2);
    step(2);
    checkOutput("hold_up_3", 32'(floor), 32'd2);
    applyStimulus(2'b00, 1'b0, 4'd0);
    step(1);
    checkOutput("hold_release", 32'(floor), 32'd2);
    applyStimulus(2'b10, 1'b0, 4'd0);
    step(1);
    checkOutput("second_up", 32'(floor), 32'd3);
    applyStimulus(2'b00, 1'b0, 4'd0);
    step(1);
    checkOutput("hold_err", 32'(range_err), 32'd0);

    // Climb to the top, then bump the ceiling.
    for (int i = 0; i < 5; i++) pulseDir(2'b10);
    checkOutput("top_floor", 32'(floor), 32'd8);
    checkOutput("top_err_clear", 32'(range_err), 32'd0);
    pulseDir(2'b10);
    checkOutput("top_block_floor", 32'(floor), 32'd8);
    checkOutput("top_block_err", 32'(range_err), 32'd1);
    pulseDir(2'b01);
    checkOutput("top_down_floor", 32'(floor), 32'd7);
    checkOutput("top_err_sticky", 32'(range_err), 32'd1);
    doReset();
    step(1);
    checkOutput("err_cleared", 32'(range_err), 32'd0);

    // Down at the bottom is blocked.
    pulseDir(2'b01);
    checkOutput("bot_block_floor", 32'(floor), 32'd1);
    checkOutput("bot_block_err", 32'(range_err), 32'd1);

    // Illegal encoding at floor 3.
    doReset();
    pulseDir(2'b10);
    pulseDir(2'b10);
    checkOutput("ill_pre_floor", 32'(floor), 32'd3);
    checkOutput("ill_pre_err", 32'(range_err), 32'd0);
    pulseDir(2'b11);
    checkOutput("ill_floor", 32'(floor), 32'd3);
    checkOutput("ill_err", 32'(range_err), 32'd1);

    // Reload on the cycle the last decrement would land.
    doReset();
    applyStimulus(2'b00, 1'b1, 4'd1);
    step(1);
    applyStimulus(2'b00, 1'b0, 4'd0);
    step(3);
    checkOutput("pri_pre_left", 32'(left), 32'd1);
    checkOutput("pri_pre_tick", 32'(tick), 32'd0);
    applyStimulus(2'b00, 1'b1, 4'd10);
    step(1);
    checkOutput("pri_left", 32'(left), 32'd10);
    checkOutput("pri_tick", 32'(tick), 32'd0);
    applyStimulus(2'b00, 1'b0, 4'd0);
    step(3);
    checkOutput("pri_next_notick", 32'(tick), 32'd0);
    step(1);
    checkOutput("pri_next_tick", 32'(tick), 32'd1);
    checkOutput("pri_next_left", 32'(left), 32'd9);

    // Loading zero stays at zero with no tick.
    applyStimulus(2'b00, 1'b1, 4'd0);
    step(1);
    applyStimulus(2'b00, 1'b0, 4'd0);
    checkOutput("zero_left", 32'(left), 32'd0);
    for (int k = 0; k < 6; k++) begin
      step(1);
      checkOutput($sformatf("zero_tick_%0d", k), 32'(tick), 32'd0);
    end

    // Reset mid-countdown at floor 6 with an error flagged.
    doReset();
    for (int i = 0; i < 5; i++) pulseDir(2'b10);
    pulseDir(2'b11);
    checkOutput("mid_floor", 32'(floor), 32'd6);
    checkOutput("mid_err", 32'(range_err), 32'd1);
    applyStimulus(2'b00, 1'b1, 4'd5);
    step(1);
    applyStimulus(2'b00, 1'b0, 4'd0);
    step(2);
    checkOutput("mid_left", 32'(left), 32'd5);
    rst = 1'b0;
    applyStimulus(2'b10, 1'b1, 4'd9);
    step(1);
    checkOutput("mid_rst_floor", 32'(floor), 32'd1);
    checkOutput("mid_rst_left", 32'(left), 32'd0);
    checkOutput("mid_rst_tick", 32'(tick), 32'd0);
    checkOutput("mid_rst_err", 32'(range_err), 32'd0);
    applyStimulus(2'b00, 1'b0, 4'd0);
    rst = 1'b1;
    step(5);
    checkOutput("post_rst_floor", 32'(floor), 32'd1);
    checkOutput("post_rst_left", 32'(left), 32'd0);

    // Floor move and countdown load in the same cycle.
    applyStimulus(2'b10, 1'b1, 4'd2);
    step(1);
    checkOutput("both_floor", 32'(floor), 32'd2);
    checkOutput("both_left", 32'(left), 32'd2);
    applyStimulus(2'b00, 1'b0, 4'd0);
    step(1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/floor_timer.md
FLOOR_TIMER -- requirements
Module: floor_timer

Interface
REQ-001 SHALL expose parameter TICK_DIV, default 50_000_000, clk cycles per one-second tick.
REQ-002 SHALL expose parameter FLOOR_MIN, default 1, lowest floor value.
REQ-003 SHALL expose parameter FLOOR_MAX, default 8, highest floor value.
REQ-004 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port change_floor  input  2  10=up one floor, 01=down one floor, 00=hold, 11=illegal.
REQ-007 SHALL have port start_cd  input  1  load countdown from seconds.
REQ-008 SHALL have port seconds  input  4  countdown load value in whole seconds.
REQ-009 SHALL have port floor  output  4  current car floor, registered.
REQ-010 SHALL have port left  output  4  seconds remaining, registered.
REQ-011 SHALL have port tick  output  1  one-cycle pulse on each countdown decrement.
REQ-012 SHALL have port range_err  output  1  sticky flag for a blocked or illegal move.

Function
REQ-013 SHALL move the floor only on a change_floor edge, where the registered previous change_floor is 00 and the current value is non-zero; a held non-zero level moves the floor exactly once.
REQ-014 SHALL set floor to floor+1 on an up edge when floor<FLOOR_MAX; at FLOOR_MAX, floor SHALL be held and range_err set.
REQ-015 SHALL set floor to floor-1 on a down edge when floor>FLOOR_MIN; at FLOOR_MIN, floor SHALL be held and range_err set.
REQ-016 SHALL, on an edge to 11, hold floor and set range_err.
REQ-017 SHALL, on start_cd=1, set left=seconds and prescaler=0 in the next cycle; one-cycle latency.
REQ-018 SHALL, while left!=0 and start_cd=0, count the prescaler 0..TICK_DIV-1; at TICK_DIV-1 the prescaler SHALL wrap to 0, left SHALL decrement and tick SHALL pulse for 1 cycle.
REQ-019 SHALL hold the prescaler at 0, keep left=0 and not pulse tick while left=0; no underflow.
REQ-020 SHALL give start_cd priority over a simultaneous decrement: the load wins and tick stays 0.
REQ-021 SHALL, when start_cd=1 with seconds=0, set left=0 with no tick.
REQ-022 SHALL process the floor move and countdown independently; both MAY update in the same cycle.
REQ-023 SHALL allow range_err to clear only by reset.

Reset
REQ-024 SHALL, while rst=0 on a clk edge, set floor=FLOOR_MIN, left=0, prescaler=0, tick=0, range_err=0 and previous change_floor=00.
REQ-025 SHALL abort any countdown or pending move when reset is applied mid-operation, and SHALL ignore start_cd and change_floor during reset.
REQ-026 SHALL resume from the reset values on the first edge with rst=1.

Configuration
REQ-027 SHALL, with macro FLOOR_TIMER_SEG_EN defined, add outputs seg_an[3:0] and seg_cat[7:0] (both active-low), scanning floor on digit 0 and left on digit 1 at clk/2^16 per digit, with digits 2-3 blank.
REQ-028 SHALL, without FLOOR_TIMER_SEG_EN, omit those ports and the scan logic entirely; behaviour of all other outputs SHALL be identical either way.

Structure
REQ-029 SHALL place the change_floor encodings (DIR_UP=2'b10, DIR_DN=2'b01, DIR_HOLD=2'b00), FLOOR_MIN/FLOOR_MAX defaults and the stop-floor constants 1, 3, 6, 8 in shared package elev_pkg.
REQ-030 SHALL implement the hex-to-segment decode as sub-module seg7_decode, instantiated only under FLOOR_TIMER_SEG_EN.

Verification (TICK_DIV=4)
REQ-031 SHALL cover: after reset, start_cd=1, seconds=3 -> left=3 next cycle; ticks at +4, +8, +12 cycles; left 2,1,0; then no further ticks.
REQ-032 SHALL cover: floor=1, change_floor=10 held for 3 cycles, then 00, then 10 for 1 cycle -> floor=2 then 3; range_err=0.
REQ-033 SHALL cover: floor=8, up edge -> floor stays 8, range_err=1 until reset; a later down edge -> floor=7.
REQ-034 SHALL cover: left=1 with the prescaler at 3, start_cd=1 with seconds=10 in the same cycle -> left=10, no tick.
REQ-035 SHALL cover: mid-countdown at left=5, floor=6, rst=0 for 1 cycle -> floor=1, left=0, tick=0, range_err=0.
REQ-036 SHALL cover: edge to change_floor=11 at floor=3 -> floor stays 3, range_err=1.
